// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage feeding the IF/ID pipeline register.
//
//   The stage owns the program counter and issues in-order word fetches to
//   instruction memory. Returned instructions are held in a small prefetch
//   queue and presented to IF/ID as {inst, pc}. A redirect from ID flushes
//   all wrong-path state.
//
//   Ports
//     clk, rst_n                    clock, asynchronous active-low reset
//     redirect_valid, redirect_pc   one-cycle redirect strobe and its target
//     imem_req_valid/ready/addr     fetch request channel (addr = PC)
//     imem_rsp_valid/data           in-order fetch responses
//     ifid_valid/ready/inst/pc      queue head toward IF/ID
//     stall_cnt                     (FETCH_STALL_CNT_EN only) cycles spent in
//                                   RUN with no instruction available
//
//   Optional feature macro: FETCH_STALL_CNT_EN
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter int              PC_W     = 8,
   parameter int              INST_W   = 32,
   parameter int              QDEPTH   = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [PC_W-1:0]   imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   output logic              ifid_valid,
   input  logic              ifid_ready,
   output logic [INST_W-1:0] ifid_inst,
   output logic [PC_W-1:0]   ifid_pc
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH) + 1;
   localparam logic [CW:0]     QD_L   = (CW+1)'(QDEPTH);
   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
   localparam logic [AW-1:0]   A_ONE  = AW'(1);
   localparam logic [CW-1:0]   C_ONE  = CW'(1);

   typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;

   state_e            state_q, state_d;
   logic              run;

   logic [PC_W-1:0]   pc_q, pc_d;
   logic [CW-1:0]     out_q, out_d;     // requests accepted, response not yet seen
   logic [CW-1:0]     drop_q, drop_d;   // wrong-path responses still to discard
   logic [CW-1:0]     cnt_q, cnt_d;     // prefetch queue occupancy
   logic [AW-1:0]     twr_q, twr_d, trd_q, trd_d;
   logic [AW-1:0]     qwr_q, qwr_d, qrd_q, qrd_d;

   logic [PC_W-1:0]   tag_mem [QDEPTH];
   logic [INST_W-1:0] q_inst  [QDEPTH];
   logic [PC_W-1:0]   q_pc    [QDEPTH];

   logic [CW:0]       occ;
   logic              req_fire, rsp_keep, pop;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= BOOT;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      run = (state_q == RUN);
   end

   // Slots committed = in flight + queued. A head leaving this cycle frees its
   // slot immediately; without that credit a 2-entry queue with 1-cycle memory
   // would insert a bubble every other instruction.
   assign pop      = ifid_valid & ifid_ready;
   assign occ      = (CW+1)'(out_q) + (CW+1)'(cnt_q) - (CW+1)'(pop);

   assign imem_req_valid = run & ~redirect_valid & (occ < QD_L);
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;
   assign rsp_keep       = imem_rsp_valid & (drop_q == '0);

   always_comb begin
      pc_d   = pc_q;
      out_d  = out_q;
      drop_d = drop_q;
      cnt_d  = cnt_q;
      twr_d  = twr_q;
      trd_d  = trd_q;
      qwr_d  = qwr_q;
      qrd_d  = qrd_q;

      if (req_fire) begin
         pc_d  = pc_q + PC_ONE;
         twr_d = twr_q + A_ONE;
      end
      // Every response, kept or dropped, retires one in-flight tag.
      if (imem_rsp_valid) trd_d = trd_q + A_ONE;

      case ({req_fire, imem_rsp_valid})
         2'b10:   out_d = out_q + C_ONE;
         2'b01:   out_d = out_q - C_ONE;
         default: out_d = out_q;
      endcase

      if (imem_rsp_valid && !rsp_keep) drop_d = drop_q - C_ONE;

      if (rsp_keep) qwr_d = qwr_q + A_ONE;
      if (pop)      qrd_d = qrd_q + A_ONE;
      case ({rsp_keep, pop})
         2'b10:   cnt_d = cnt_q + C_ONE;
         2'b01:   cnt_d = cnt_q - C_ONE;
         default: cnt_d = cnt_q;
      endcase

      // Redirect wins. The tag FIFO is left alone so later (dropped)
      // responses still retire their tags in order.
      if (redirect_valid) begin
         pc_d   = redirect_pc;
         drop_d = out_q - CW'(imem_rsp_valid);
         cnt_d  = '0;
         qwr_d  = '0;
         qrd_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         out_q  <= '0;
         drop_q <= '0;
         cnt_q  <= '0;
         twr_q  <= '0;
         trd_q  <= '0;
         qwr_q  <= '0;
         qrd_q  <= '0;
      end else begin
         pc_q   <= pc_d;
         out_q  <= out_d;
         drop_q <= drop_d;
         cnt_q  <= cnt_d;
         twr_q  <= twr_d;
         trd_q  <= trd_d;
         qwr_q  <= qwr_d;
         qrd_q  <= qrd_d;
      end
   end

   // Storage only; validity is tracked entirely by the control counters.
   always_ff @(posedge clk) begin
      if (req_fire) tag_mem[twr_q] <= pc_q;
      if (rsp_keep) begin
         q_inst[qwr_q] <= imem_rsp_data;
         q_pc[qwr_q]   <= tag_mem[trd_q];
      end
   end

   assign ifid_valid = (cnt_q != '0);
   assign ifid_inst  = ifid_valid ? q_inst[qrd_q] : '0;
   assign ifid_pc    = ifid_valid ? q_pc[qrd_q]   : '0;

`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (run && !ifid_valid && !redirect_valid && (stall_q != 16'hFFFF))
         stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage (PC_W=8, INST_W=32, QDEPTH=2, RESET_PC=0).
//   A behavioural instruction memory returns inst_of(addr) in order after a
//   configurable latency; scenario tasks check the IF/ID stream inline.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [7:0]  imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        ifid_valid;
   logic        ifid_ready;
   logic [31:0] ifid_inst;
   logic [7:0]  ifid_pc;
`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   fetch_stage #(.PC_W(8), .INST_W(32), .QDEPTH(2), .RESET_PC(8'h00)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .ifid_valid     (ifid_valid),
      .ifid_ready     (ifid_ready),
      .ifid_inst      (ifid_inst),
      .ifid_pc        (ifid_pc)
`ifdef FETCH_STALL_CNT_EN
      ,
      .stall_cnt      (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_pc = 8'h00;
   int         issued = 0;
   int         popped = 0;

   // memory model state
   logic [7:0] pend_addr[$];
   int         pend_due[$];
   int         cyc = 0;
   int         last_due = 0;
   bit         mem_hold = 1'b0;
   bit         rand_mode = 1'b0;

   function automatic logic [31:0] inst_of(input logic [7:0] a);
      return {16'hC0DE, ~a, a};
   endfunction

   // Instruction memory: records accepted requests at the falling edge and
   // presents responses from just after the rising edge, in order.
   initial begin : responder
      int d;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend_addr.delete();
            pend_due.delete();
            last_due = 0;
         end else if (imem_req_valid && imem_req_ready) begin
            d = cyc + (rand_mode ? int'($urandom_range(3, 1)) : 1);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(d);
            issued++;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (!mem_hold && pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
         imem_req_ready = rand_mode ? 1'($urandom_range(1, 0)) : 1'b1;
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; ifid_ready = 1'b1;
      #2;
      tests++;
      if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b0) begin
         fails++; $display("FAIL reset_valids: got req=%0b ifid=%0b expected 0 0", imem_req_valid, ifid_valid);
      end
      tests++;
      if (ifid_inst !== 32'h0 || ifid_pc !== 8'h00) begin
         fails++; $display("FAIL reset_ifid_data: got inst=%0h pc=%0h expected 0 0", ifid_inst, ifid_pc);
      end
`ifdef FETCH_STALL_CNT_EN
      tests++;
      if (stall_cnt !== 16'h0) begin fails++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b0) begin
         fails++; $display("FAIL reset_held: got req=%0b ifid=%0b expected 0 0", imem_req_valid, ifid_valid);
      end
   endtask

   task automatic test_startup();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k == 0) begin
            tests++;
            if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL boot_no_req: got %0b expected 0", imem_req_valid); end
         end else begin
            tests++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 8'(k-1)) begin
               fails++; $display("FAIL startup_req k=%0d: got valid=%0b addr=%0h expected valid=1 addr=%0h", k, imem_req_valid, imem_req_addr, 8'(k-1));
            end
         end
         if (k < 3) begin
            tests++;
            if (ifid_valid !== 1'b0) begin fails++; $display("FAIL startup_latency k=%0d: got ifid_valid=%0b expected 0", k, ifid_valid); end
         end else begin
            tests++;
            if (ifid_valid !== 1'b1 || ifid_pc !== 8'(k-3) || ifid_inst !== inst_of(8'(k-3))) begin
               fails++; $display("FAIL startup_stream k=%0d: got v=%0b pc=%0h inst=%0h expected v=1 pc=%0h inst=%0h", k, ifid_valid, ifid_pc, ifid_inst, 8'(k-3), inst_of(8'(k-3)));
            end
         end
`ifdef FETCH_STALL_CNT_EN
         if (k == 3) begin
            tests++;
            if (stall_cnt !== 16'd2) begin fails++; $display("FAIL startup_stall_cnt: got %0d expected 2", stall_cnt); end
         end
`endif
         if (ifid_valid && ifid_ready) begin popped++; exp_pc++; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      int got = 0;
      ifid_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         tests++;
         if (ifid_valid !== 1'b1 || ifid_pc !== exp_pc || imem_req_valid !== 1'b0) begin
            fails++; $display("FAIL stall_hold k=%0d: got v=%0b pc=%0h req=%0b expected v=1 pc=%0h req=0", k, ifid_valid, ifid_pc, imem_req_valid, exp_pc);
         end
         if (k == 9) begin
            #1;
            tests++;
            if (issued - popped !== 2) begin fails++; $display("FAIL stall_credit: got %0d in flight+queued expected 2", issued - popped); end
         end
         @(posedge clk); #1;
      end
      ifid_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ifid_valid && ifid_ready) begin
            tests++;
            if (ifid_pc !== exp_pc || ifid_inst !== inst_of(exp_pc)) begin
               fails++; $display("FAIL stall_release: got pc=%0h inst=%0h expected pc=%0h inst=%0h", ifid_pc, ifid_inst, exp_pc, inst_of(exp_pc));
            end
            exp_pc++; popped++; got++;
         end
         @(posedge clk); #1;
      end
      tests++;
      if (got !== 8) begin fails++; $display("FAIL stall_release_rate: got %0d transfers expected 8", got); end
   endtask

   task automatic test_redirect();
      int got = 0;
      @(negedge clk);
      if (ifid_valid && ifid_ready) begin exp_pc++; popped++; end
      mem_hold = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (ifid_valid && ifid_ready) begin
            tests++;
            if (ifid_pc !== exp_pc) begin fails++; $display("FAIL redirect_drain: got pc=%0h expected %0h", ifid_pc, exp_pc); end
            exp_pc++; popped++;
         end
         if (k == 3) begin
            tests++;
            if (ifid_valid !== 1'b0 || imem_req_valid !== 1'b0 || pend_addr.size() !== 2) begin
               fails++; $display("FAIL redirect_setup: got ifid=%0b req=%0b outstanding=%0d expected 0 0 2", ifid_valid, imem_req_valid, pend_addr.size());
            end
            mem_hold = 1'b0;
         end
         @(posedge clk); #1;
      end
      redirect_valid = 1'b1; redirect_pc = 8'h40;
      @(negedge clk);
      tests++;
      if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL redirect_gates_req: got %0b expected 0", imem_req_valid); end
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      exp_pc = 8'h40;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) begin
            tests++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 8'h40) begin
               fails++; $display("FAIL redirect_first_req: got valid=%0b addr=%0h expected 1 40", imem_req_valid, imem_req_addr);
            end
         end
         if (ifid_valid && ifid_ready) begin
            tests++;
            if (ifid_pc !== exp_pc || ifid_inst !== inst_of(exp_pc)) begin
               fails++; $display("FAIL redirect_stream: got pc=%0h inst=%0h expected pc=%0h inst=%0h", ifid_pc, ifid_inst, exp_pc, inst_of(exp_pc));
            end
            exp_pc++; got++;
         end
         @(posedge clk); #1;
      end
      tests++;
      if (got < 4) begin fails++; $display("FAIL redirect_count: got %0d transfers expected at least 4", got); end
   endtask

   task automatic test_wrap();
      int   got = 0;
      bit   after_ff = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 8'hFE;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      exp_pc = 8'hFE;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) begin
            if (after_ff) begin
               tests++;
               if (imem_req_addr !== 8'h00) begin fails++; $display("FAIL wrap_req_addr: got %0h expected 00", imem_req_addr); end
            end
            after_ff = (imem_req_addr == 8'hFF);
         end
         if (ifid_valid && ifid_ready) begin
            tests++;
            if (ifid_pc !== exp_pc || ifid_inst !== inst_of(exp_pc)) begin
               fails++; $display("FAIL wrap_stream: got pc=%0h inst=%0h expected pc=%0h inst=%0h", ifid_pc, ifid_inst, exp_pc, inst_of(exp_pc));
            end
            exp_pc++; got++;
         end
         @(posedge clk); #1;
      end
      tests++;
      if (got < 6) begin fails++; $display("FAIL wrap_count: got %0d transfers expected at least 6", got); end
   endtask

   task automatic test_random();
      int got = 0;
      rand_mode = 1'b1;
      for (int k = 0; k < 300; k++) begin
         ifid_ready = ($urandom_range(3, 0) != 0);
         @(negedge clk);
         if (ifid_valid && ifid_ready) begin
            tests++;
            if (ifid_pc !== exp_pc || ifid_inst !== inst_of(exp_pc)) begin
               fails++; $display("FAIL random_stream: got pc=%0h inst=%0h expected pc=%0h inst=%0h", ifid_pc, ifid_inst, exp_pc, inst_of(exp_pc));
            end
            exp_pc++; got++;
         end
         @(posedge clk); #1;
      end
      rand_mode = 1'b0;
      ifid_ready = 1'b1;
      tests++;
      if (got < 60) begin fails++; $display("FAIL random_count: got %0d transfers expected at least 60", got); end
   endtask

   task automatic test_reset_mid();
      repeat (4) @(posedge clk);
      #3;
      tests++;
      if (ifid_valid !== 1'b1) begin fails++; $display("FAIL midreset_pre: got ifid_valid=%0b expected 1", ifid_valid); end
      rst_n = 1'b0;
      #1;
      tests++;
      if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b0 || ifid_inst !== 32'h0 || ifid_pc !== 8'h00) begin
         fails++; $display("FAIL midreset_async: got req=%0b v=%0b inst=%0h pc=%0h expected all 0", imem_req_valid, ifid_valid, ifid_inst, ifid_pc);
      end
`ifdef FETCH_STALL_CNT_EN
      tests++;
      if (stall_cnt !== 16'h0) begin fails++; $display("FAIL midreset_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_pc = 8'h00;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            tests++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 8'h00) begin
               fails++; $display("FAIL restart_req: got valid=%0b addr=%0h expected 1 00", imem_req_valid, imem_req_addr);
            end
         end
         if (k == 3) begin
            tests++;
            if (ifid_valid !== 1'b1 || ifid_pc !== 8'h00) begin
               fails++; $display("FAIL restart_first: got v=%0b pc=%0h expected 1 00", ifid_valid, ifid_pc);
            end
`ifdef FETCH_STALL_CNT_EN
            tests++;
            if (stall_cnt !== 16'd2) begin fails++; $display("FAIL restart_stall_cnt: got %0d expected 2", stall_cnt); end
`endif
         end
         if (ifid_valid && ifid_ready) begin
            tests++;
            if (ifid_pc !== exp_pc || ifid_inst !== inst_of(exp_pc)) begin
               fails++; $display("FAIL restart_stream: got pc=%0h inst=%0h expected pc=%0h inst=%0h", ifid_pc, ifid_inst, exp_pc, inst_of(exp_pc));
            end
            exp_pc++;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin : main
      test_reset();
      test_startup();
      test_stall();
      test_redirect();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
